reorder_buffer: RTL and testbench
=================================

Name: reorder_buffer

Overview:
- 32-entry circular reorder buffer between rename/dispatch (allocation) and the free list / architectural map (commit).
- Allocates one ROB tag per renamed instruction and records pd_new, pd_old and pc.
- Collects completion from the ALU, MEM and branch units and retires strictly in program order, one entry per cycle.
- On branch mispredict, squashes every entry younger than the mispredicting tag.

Parameters:
DEPTH, 32, number of entries; must equal 2^PTR_W
PTR_W, 5, tag/pointer width; matches rob_index/rob_tag width
PREG_W, 7, physical register index width

Ports:
clk  input  1  clock, rising edge
reset_n  input  1  asynchronous, active-low reset
alloc_valid  input  1  rename presents an instruction for allocation
alloc_pd_new  input  PREG_W  newly mapped physical destination
alloc_pd_old  input  PREG_W  previous mapping of the destination, freed at commit
alloc_pc  input  32  instruction pc
alloc_ready  output  1  entry available (count < DEPTH)
alloc_tag  output  PTR_W  tag granted this cycle (current tail)
alu_done  input  1  ALU completion
alu_tag  input  PTR_W  ALU completing tag
mem_done  input  1  MEM completion
mem_tag  input  PTR_W  MEM completing tag
br_done  input  1  branch completion
br_tag  input  PTR_W  branch completing tag
mispredict  input  1  branch unit reports a mispredict
mispredict_tag  input  PTR_W  tag of the mispredicting branch; this entry is kept
commit_valid  output  1  head entry retires this cycle
commit_tag  output  PTR_W  retiring tag
commit_pd_old  output  PREG_W  register returned to the free list
commit_pd_new  output  PREG_W  register made architectural
commit_pc  output  32  retiring pc
full  output  1  count == DEPTH
empty  output  1  count == 0

Behaviour:
- State:
  - head, tail: PTR_W-bit registers.
  - count: (PTR_W+1)-bit register.
  - Per entry: valid, complete, pd_new, pd_old, pc.
- Reset (asynchronous, takes effect immediately with no clock edge): head = tail = count = 0; all valid/complete = 0.
  - Resulting outputs: alloc_ready = 1, alloc_tag = 0, empty = 1, full = 0, commit_valid = 0, all commit_* = 0.
  - Reset mid-operation discards all entries.
- Allocation:
  - Fires when alloc_valid & alloc_ready & !mispredict.
  - Entry[tail] gets valid = 1, complete = 0 and the payload; tail <= tail+1 (mod 32, natural wrap).
  - alloc_tag = tail, combinational.
  - alloc_ready is derived from registered count only. A commit in the same cycle does not unblock a full ROB; the slot becomes allocatable next cycle.
- Completion:
  - Each done port sets complete for its tag, effective at the next edge.
  - Any subset of the three ports may fire in one cycle. If several ports name the same tag, the set is ORed.
  - Completion to an entry with valid = 0 (squashed or stale) is ignored.
- Commit:
  - commit_valid = entry[head].valid & entry[head].complete, computed combinationally from registered state.
  - Downstream always accepts. On commit: entry[head].valid = 0, complete = 0; head <= head+1.
  - commit_* reflect entry[head]; they are zero when commit_valid = 0.
  - Minimum latency: completion at edge N gives commit_valid during cycle N..N+1.
  - A branch completing and mispredicting in the same cycle cannot commit in that cycle.
- Count:
  - count += alloc - commit.
  - Simultaneous alloc and commit leaves count unchanged.
- Mispredict (priority over allocation):
  - Clear valid/complete on every entry from mispredict_tag+1 through tail-1, circularly.
  - tail <= mispredict_tag+1.
  - count <= ((mispredict_tag - head) mod 32) + 1 - commit_this_cycle. The +1 form keeps count = 32 correct when mispredict_tag = tail-1 on a full buffer.
  - alloc_valid in the same cycle is dropped, and rename must re-present it.
  - Commit in the same cycle proceeds normally, because head is never younger than mispredict_tag.
  - Completions in the same cycle targeting squashed tags are ignored.
  - Free-list recovery of squashed pd_new is out of scope for this block.
- Wrap-around: pointers wrap 31 -> 0; full/empty are distinguished by count, not by pointer equality.

Test Plan:
- In-order retire: after reset, alloc pd_new 40/41/42 with pd_old 5/6/7 -> alloc_tag 0,1,2.
  - alu_done tag1, then mem_done tag0 -> commit tag0 (pd_old 5) next cycle, then tag1 (pd_old 6) the following cycle.
  - Tag2 does not commit until br_done tag2.
- Full and wrap: alloc 32 entries -> full = 1, alloc_ready = 0; an extra alloc_valid is ignored.
  - Complete tag0 -> commit tag0; alloc_ready = 1 only the next cycle; the next alloc gets tag 0 (wrap); count = 32.
- Mispredict squash: alloc tags 0..9, then mispredict_tag = 4 with alloc_valid = 1.
  - Response: tail = 5, count = 5, alloc dropped; next alloc_tag = 5.
  - A later alu_done tag 7 is ignored, and tag 7 never commits.
- Simultaneous completions: alu tag2, mem tag3, br tag0 in one cycle, head = 0.
  - Tag0 commits next cycle, then commits stall until tag1 completes; then tags 1, 2, 3 retire on consecutive cycles.
- Full-buffer mispredict: buffer full, head = 0, mispredict_tag = 31 -> count stays 32, nothing squashed. Also check mispredict_tag = 0 -> count = 1, tail = 1.
- Async reset: 10 live entries, assert reset_n low between edges -> commit_valid = 0, empty = 1, alloc_tag = 0 immediately, with no clock edge.

Source files
------------

// File: rtl/reorder_buffer.sv
// 32-entry circular reorder buffer: in-order allocation and retirement,
// out-of-order completion from ALU/MEM/branch, and mispredict squash.
module reorder_buffer #(
    parameter int DEPTH  = 32,
    parameter int PTR_W  = 5,
    parameter int PREG_W = 7
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              alloc_valid,
    input  logic [PREG_W-1:0] alloc_pd_new,
    input  logic [PREG_W-1:0] alloc_pd_old,
    input  logic [31:0]       alloc_pc,
    output logic              alloc_ready,
    output logic [PTR_W-1:0]  alloc_tag,
    input  logic              alu_done,
    input  logic [PTR_W-1:0]  alu_tag,
    input  logic              mem_done,
    input  logic [PTR_W-1:0]  mem_tag,
    input  logic              br_done,
    input  logic [PTR_W-1:0]  br_tag,
    input  logic              mispredict,
    input  logic [PTR_W-1:0]  mispredict_tag,
    output logic              commit_valid,
    output logic [PTR_W-1:0]  commit_tag,
    output logic [PREG_W-1:0] commit_pd_old,
    output logic [PREG_W-1:0] commit_pd_new,
    output logic [31:0]       commit_pc,
    output logic              full,
    output logic              empty
);

    localparam logic [PTR_W:0]   FULL_CNT = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d;
    logic [PTR_W:0]    count_q, count_d;
    logic [DEPTH-1:0]  valid_q, valid_d, complete_q, complete_d;
    logic [DEPTH-1:0]  done_hit, squash;
    logic [PTR_W-1:0]  squash_span, keep_span, offset;
    logic [PREG_W-1:0] pd_new_q [DEPTH];
    logic [PREG_W-1:0] pd_old_q [DEPTH];
    logic [31:0]       pc_q     [DEPTH];
    logic              alloc_fire, commit_fire;

    assign alloc_ready = (count_q != FULL_CNT);
    assign full        = (count_q == FULL_CNT);
    assign empty       = (count_q == '0);
    assign alloc_tag   = tail_q;
    assign alloc_fire  = alloc_valid & alloc_ready & ~mispredict;
    assign commit_fire = valid_q[head_q] & complete_q[head_q];

    assign commit_valid  = commit_fire;
    assign commit_tag    = commit_fire ? head_q           : '0;
    assign commit_pd_old = commit_fire ? pd_old_q[head_q] : '0;
    assign commit_pd_new = commit_fire ? pd_new_q[head_q] : '0;
    assign commit_pc     = commit_fire ? pc_q[head_q]     : '0;

    // Squash range is mispredict_tag+1 .. tail-1, measured as a circular offset
    // so a full buffer with mispredict_tag = tail-1 squashes nothing.
    always_comb begin
        squash_span = tail_q - mispredict_tag - PTR_ONE;
        keep_span   = mispredict_tag - head_q;
        squash      = '0;
        done_hit    = '0;
        offset      = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            offset      = PTR_W'(i) - mispredict_tag - PTR_ONE;
            squash[i]   = mispredict && (offset < squash_span);
            done_hit[i] = (alu_done && alu_tag == PTR_W'(i)) ||
                          (mem_done && mem_tag == PTR_W'(i)) ||
                          (br_done  && br_tag  == PTR_W'(i));
        end
    end

    always_comb begin
        valid_d    = valid_q;
        complete_d = complete_q | (valid_q & done_hit);
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (commit_fire && head_q == PTR_W'(i)) begin
                valid_d[i]    = 1'b0;
                complete_d[i] = 1'b0;
            end
            if (squash[i]) begin
                valid_d[i]    = 1'b0;
                complete_d[i] = 1'b0;
            end
            if (alloc_fire && tail_q == PTR_W'(i)) begin
                valid_d[i]    = 1'b1;
                complete_d[i] = 1'b0;
            end
        end
    end

    always_comb begin
        head_d = head_q + PTR_W'(commit_fire);
        if (mispredict) begin
            tail_d  = mispredict_tag + PTR_ONE;
            count_d = {1'b0, keep_span} + CNT_ONE - (PTR_W+1)'(commit_fire);
        end else begin
            tail_d  = tail_q + PTR_W'(alloc_fire);
            count_d = count_q + (PTR_W+1)'(alloc_fire) - (PTR_W+1)'(commit_fire);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            valid_q    <= '0;
            complete_q <= '0;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            valid_q    <= valid_d;
            complete_q <= complete_d;
        end
    end

    // Payload needs no reset: it is only observed through a valid, complete head.
    always_ff @(posedge clk) begin
        if (alloc_fire) begin
            pd_new_q[tail_q] <= alloc_pd_new;
            pd_old_q[tail_q] <= alloc_pd_old;
            pc_q[tail_q]     <= alloc_pc;
        end
    end

endmodule

// File: tb/tb_reorder_buffer.sv
// Reorder buffer bench: queue-based program-order model, commit scoreboard,
// directed scenarios followed by randomized traffic.
module tb_reorder_buffer;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        alloc_valid;
    logic [6:0]  alloc_pd_new, alloc_pd_old;
    logic [31:0] alloc_pc;
    logic        alloc_ready;
    logic [4:0]  alloc_tag;
    logic        alu_done, mem_done, br_done, mispredict;
    logic [4:0]  alu_tag, mem_tag, br_tag, mispredict_tag;
    logic        commit_valid;
    logic [4:0]  commit_tag;
    logic [6:0]  commit_pd_old, commit_pd_new;
    logic [31:0] commit_pc;
    logic        full, empty;

    reorder_buffer #(.DEPTH(32), .PTR_W(5), .PREG_W(7)) dut (
        .clk(clk), .reset_n(reset_n),
        .alloc_valid(alloc_valid), .alloc_pd_new(alloc_pd_new),
        .alloc_pd_old(alloc_pd_old), .alloc_pc(alloc_pc),
        .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
        .alu_done(alu_done), .alu_tag(alu_tag),
        .mem_done(mem_done), .mem_tag(mem_tag),
        .br_done(br_done), .br_tag(br_tag),
        .mispredict(mispredict), .mispredict_tag(mispredict_tag),
        .commit_valid(commit_valid), .commit_tag(commit_tag),
        .commit_pd_old(commit_pd_old), .commit_pd_new(commit_pd_new),
        .commit_pc(commit_pc), .full(full), .empty(empty)
    );

    always #5 clk = ~clk;

    typedef struct { int tag; int pdn; int pdo; logic [31:0] pc; bit done; } ent_t;
    typedef struct { int cyc; int tag; int pdn; int pdo; logic [31:0] pc; } exp_t;

    ent_t rob[$];     // live instructions, oldest first
    exp_t exp_q[$];   // expected commits
    int   mtail = 0;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(string name, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, got, exp, $time);
        end
    endfunction

    // Monitor: compares whatever the DUT retires against the scoreboard.
    always @(negedge clk) begin
        if (reset_n) begin
            bit   exp_now;
            exp_t x;
            exp_now = (exp_q.size() > 0) && (exp_q[0].cyc == cyc);
            check("commit_valid", {31'b0, commit_valid}, {31'b0, exp_now});
            if (exp_now) begin
                x = exp_q.pop_front();
                if (commit_valid) begin
                    check("commit_tag", {27'b0, commit_tag}, x.tag);
                    check("commit_pd_old", {25'b0, commit_pd_old}, x.pdo);
                    check("commit_pd_new", {25'b0, commit_pd_new}, x.pdn);
                    check("commit_pc", commit_pc, x.pc);
                end
            end else if (!commit_valid) begin
                check("commit_idle_zero", {13'b0, commit_tag, commit_pd_old, commit_pd_new}, 0);
                check("commit_idle_pc", commit_pc, 0);
            end
        end
    end

    task automatic idle();
        alloc_valid = 0; alloc_pd_new = '0; alloc_pd_old = '0; alloc_pc = '0;
        alu_done = 0; alu_tag = '0; mem_done = 0; mem_tag = '0;
        br_done = 0; br_tag = '0; mispredict = 0; mispredict_tag = '0;
    endtask

    task automatic set_alloc(int pdn, int pdo, int pc);
        alloc_valid = 1; alloc_pd_new = 7'(pdn); alloc_pd_old = 7'(pdo); alloc_pc = 32'(pc);
    endtask

    // Called at posedge+1 with inputs driven; advances one clock and the model.
    task automatic tick();
        bit   commit_now, alloc_now;
        int   idx;
        exp_t x;
        check("alloc_tag", {27'b0, alloc_tag}, mtail);
        check("alloc_ready", {31'b0, alloc_ready}, (rob.size() < 32) ? 1 : 0);
        check("full", {31'b0, full}, (rob.size() == 32) ? 1 : 0);
        check("empty", {31'b0, empty}, (rob.size() == 0) ? 1 : 0);
        commit_now = (rob.size() > 0) && rob[0].done;
        alloc_now  = alloc_valid && (rob.size() < 32) && !mispredict;
        if (commit_now) begin
            x = '{cyc: cyc, tag: rob[0].tag, pdn: rob[0].pdn, pdo: rob[0].pdo, pc: rob[0].pc};
            exp_q.push_back(x);
        end
        @(posedge clk);
        foreach (rob[k])
            if ((alu_done && rob[k].tag == int'(alu_tag)) ||
                (mem_done && rob[k].tag == int'(mem_tag)) ||
                (br_done  && rob[k].tag == int'(br_tag)))
                rob[k].done = 1;
        if (mispredict) begin
            idx = -1;
            foreach (rob[k]) if (rob[k].tag == int'(mispredict_tag)) idx = k;
            if (idx < 0) $display("bench note: mispredict on a tag that is not live");
            while (rob.size() > idx + 1) void'(rob.pop_back());
            mtail = (int'(mispredict_tag) + 1) % 32;
        end
        if (commit_now) void'(rob.pop_front());
        if (alloc_now) begin
            rob.push_back('{tag: mtail, pdn: int'(alloc_pd_new), pdo: int'(alloc_pd_old),
                            pc: alloc_pc, done: 0});
            mtail = (mtail + 1) % 32;
        end
        #1;
    endtask

    task automatic do_reset();
        reset_n = 0;
        idle();
        rob.delete();
        exp_q.delete();
        mtail = 0;
        #2;
        check("rst_alloc_ready", {31'b0, alloc_ready}, 1);
        check("rst_alloc_tag", {27'b0, alloc_tag}, 0);
        check("rst_empty", {31'b0, empty}, 1);
        check("rst_full", {31'b0, full}, 0);
        check("rst_commit_valid", {31'b0, commit_valid}, 0);
        check("rst_commit_zero", {13'b0, commit_tag, commit_pd_old, commit_pd_new}, 0);
        @(posedge clk);
        #1;
        reset_n = 1;
    endtask

    task automatic run_idle(int n);
        for (int i = 0; i < n; i++) begin
            idle();
            tick();
        end
    endtask

    task automatic alloc_n(int n);
        for (int i = 0; i < n; i++) begin
            idle();
            set_alloc(64 + i, i, 32'h1000 + 4 * i);
            tick();
        end
    endtask

    initial begin
        idle();
        do_reset();

        // In-order retire
        for (int i = 0; i < 3; i++) begin
            idle();
            check("seq_alloc_tag", {27'b0, alloc_tag}, i);
            set_alloc(40 + i, 5 + i, 32'h100 + 4 * i);
            tick();
        end
        idle(); alu_done = 1; alu_tag = 5'd1; tick();
        idle(); mem_done = 1; mem_tag = 5'd0; tick();
        check("tag0_commits", {25'b0, commit_pd_old}, 5);
        run_idle(1);
        check("tag1_commits", {25'b0, commit_pd_old}, 6);
        run_idle(2);
        check("tag2_waits", {31'b0, commit_valid}, 0);
        idle(); br_done = 1; br_tag = 5'd2; tick();
        run_idle(2);

        // Full and wrap
        do_reset();
        alloc_n(32);
        check("full_set", {31'b0, full}, 1);
        check("full_not_ready", {31'b0, alloc_ready}, 0);
        idle(); set_alloc(99, 99, 32'hdead); tick();
        idle(); alu_done = 1; alu_tag = 5'd0; tick();
        check("commit_does_not_unblock", {31'b0, alloc_ready}, 0);
        idle(); set_alloc(98, 98, 32'hbeef); tick();
        check("ready_after_commit", {31'b0, alloc_ready}, 1);
        check("wrap_tag", {27'b0, alloc_tag}, 0);
        idle(); set_alloc(97, 97, 32'hcafe); tick();
        check("full_again", {31'b0, full}, 1);

        // Mispredict squash with dropped alloc
        do_reset();
        alloc_n(10);
        idle(); set_alloc(120, 1, 32'h9999); mispredict = 1; mispredict_tag = 5'd4; tick();
        check("squash_tail", {27'b0, alloc_tag}, 5);
        idle(); alu_done = 1; alu_tag = 5'd7; tick();
        for (int t = 0; t < 5; t++) begin
            idle(); alu_done = 1; alu_tag = 5'(t); tick();
        end
        run_idle(6);
        check("squash_drained", {31'b0, empty}, 1);

        // Simultaneous completions
        do_reset();
        alloc_n(4);
        idle();
        alu_done = 1; alu_tag = 5'd2; mem_done = 1; mem_tag = 5'd3; br_done = 1; br_tag = 5'd0;
        tick();
        run_idle(3);
        idle(); alu_done = 1; alu_tag = 5'd1; tick();
        run_idle(5);

        // Mispredict on a full buffer
        do_reset();
        alloc_n(32);
        idle(); mispredict = 1; mispredict_tag = 5'd31; tick();
        check("full_mp31_full", {31'b0, full}, 1);
        idle(); mispredict = 1; mispredict_tag = 5'd0; tick();
        check("mp0_tail", {27'b0, alloc_tag}, 1);
        check("mp0_not_empty", {31'b0, empty}, 0);
        idle(); br_done = 1; br_tag = 5'd0; tick();
        run_idle(3);

        // Asynchronous reset between edges
        do_reset();
        alloc_n(10);
        idle(); alu_done = 1; alu_tag = 5'd0; tick();
        check("pre_reset_commit", {31'b0, commit_valid}, 1);
        #2;
        reset_n = 0;
        #1;
        check("async_commit_valid", {31'b0, commit_valid}, 0);
        check("async_empty", {31'b0, empty}, 1);
        check("async_alloc_tag", {27'b0, alloc_tag}, 0);
        @(posedge clk);
        #1;
        do_reset();

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            int cprob;
            cprob = ((n / 300) % 2 == 0) ? 7 : 1;
            idle();
            if ($urandom_range(9) < 7)
                set_alloc(int'($urandom_range(127)), int'($urandom_range(127)), int'($urandom));
            if (rob.size() > 0 && $urandom_range(24) == 0) begin
                mispredict = 1;
                mispredict_tag = 5'(rob[$urandom_range(rob.size() - 1)].tag);
            end
            if ($urandom_range(7) < cprob) begin
                alu_done = 1;
                alu_tag = (rob.size() > 0 && $urandom_range(4) != 0) ?
                          5'(rob[$urandom_range(rob.size() - 1)].tag) : 5'($urandom_range(31));
            end
            if ($urandom_range(7) < cprob) begin
                mem_done = 1;
                mem_tag = (rob.size() > 0 && $urandom_range(4) != 0) ?
                          5'(rob[$urandom_range(rob.size() - 1)].tag) : 5'($urandom_range(31));
            end
            if ($urandom_range(7) < cprob) begin
                br_done = 1;
                br_tag = (rob.size() > 0 && $urandom_range(4) != 0) ?
                         5'(rob[$urandom_range(rob.size() - 1)].tag) : 5'($urandom_range(31));
            end
            tick();
        end

        for (int n = 0; n < 200 && rob.size() > 0; n++) begin
            idle();
            alu_done = 1;
            alu_tag = 5'(rob[rob.size() - 1].tag);
            mem_done = 1;
            mem_tag = 5'(rob[0].tag);
            tick();
        end
        run_idle(3);
        check("final_empty", {31'b0, empty}, 1);
        check("scoreboard_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
